// File: rtl/rob_core.sv
// rob_core: reorder buffer allocating in-order tags, resolving operands and committing in order.
// Define ROB_FLUSH_EN to add the iFlush port, which empties the buffer in one cycle.
module rob_core #(
    parameter int ROB_SIZE  = 16,
    parameter int REG_ADD_W = 5,
    parameter int REG_DAT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
`ifdef ROB_FLUSH_EN
    input  logic                 iFlush,
`endif
    input  logic                 iIS_En,
    input  logic                 iIS_EnRd,
    input  logic [REG_ADD_W-1:0] iIS_Rd,
    input  logic [REG_ADD_W-1:0] iIS_Rs1,
    input  logic [REG_ADD_W-1:0] iIS_Rs2,
    output logic                 oIS_Full,
    output logic [REG_ADD_W-1:0] oRF_Qn,
    input  logic                 iRF_En,
    input  logic [REG_ADD_W-1:0] iRF_Qs1,
    input  logic [REG_ADD_W-1:0] iRF_Qs2,
    input  logic [REG_DAT_W-1:0] iRF_Vs1,
    input  logic [REG_DAT_W-1:0] iRF_Vs2,
    input  logic                 iCDB_En,
    input  logic [REG_ADD_W-1:0] iCDB_Tag,
    input  logic [REG_DAT_W-1:0] iCDB_Val,
    output logic                 oRS_En,
    output logic [REG_ADD_W-1:0] oRS_Tag,
    output logic [REG_ADD_W-1:0] oRS_Qs1,
    output logic [REG_ADD_W-1:0] oRS_Qs2,
    output logic [REG_DAT_W-1:0] oRS_Vs1,
    output logic [REG_DAT_W-1:0] oRS_Vs2,
    output logic                 oRF_En,
    output logic [REG_ADD_W-1:0] oRF_Rd,
    output logic [REG_DAT_W-1:0] oRF_Vd
);
    localparam int IW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int AW = REG_ADD_W;
    localparam int DW = REG_DAT_W;
    typedef logic [IW-1:0] idx_t;

    logic          busy_q  [ROB_SIZE];
    logic          ready_q [ROB_SIZE];
    logic          enrd_q  [ROB_SIZE];
    logic [AW-1:0] rd_q    [ROB_SIZE];
    logic [DW-1:0] val_q   [ROB_SIZE];
    logic [AW-1:0] rs1_q   [ROB_SIZE];
    logic [AW-1:0] rs2_q   [ROB_SIZE];
    idx_t          head_q, head_d, tail_q, tail_d, pidx_q, pidx_d, cdb_idx;
    logic [IW:0]   cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          flush, full, commit, alloc, resolve, cdb_ok;
    logic          rs_en_q;
    logic [AW-1:0] rs_tag_q, rs_qs1_q, rs_qs2_q, rs_qs1_d, rs_qs2_d;
    logic [DW-1:0] rs_vs1_q, rs_vs2_q, rs_vs1_d, rs_vs2_d;

`ifdef ROB_FLUSH_EN
    assign flush = iFlush;
`else
    assign flush = 1'b0;
`endif

    function automatic idx_t wrap(input idx_t i);
        return (i == idx_t'(ROB_SIZE - 1)) ? '0 : i + idx_t'(1);
    endfunction

    // A returned tag only counts if it still names a live producer of this same register.
    function automatic logic [AW+DW-1:0] res(input logic [AW-1:0] rs, input logic [AW-1:0] qs,
                                             input logic [DW-1:0] vs);
        idx_t i;
        logic live;
        i    = idx_t'(qs - AW'(1));
        live = (qs != '0) && (qs <= AW'(ROB_SIZE)) && busy_q[i] && (rd_q[i] == rs);
        return (rs == '0) ? '0 :
               !live ? {AW'(0), vs} :
               ready_q[i] ? {AW'(0), val_q[i]} :
               (iCDB_En && iCDB_Tag == qs) ? {AW'(0), iCDB_Val} : {qs, DW'(0)};
    endfunction

    always_comb begin
        full    = cnt_q == (IW+1)'(ROB_SIZE);
        commit  = en && !flush && busy_q[head_q] && ready_q[head_q];
        alloc   = en && !flush && iIS_En && (!full || commit);
        resolve = en && !flush && pend_q && iRF_En;
        cdb_idx = idx_t'(iCDB_Tag - AW'(1));
        cdb_ok  = en && !flush && iCDB_En && (iCDB_Tag != '0) && (iCDB_Tag <= AW'(ROB_SIZE)) && busy_q[cdb_idx];
        head_d  = flush ? '0 : commit ? wrap(head_q) : head_q;
        tail_d  = flush ? '0 : alloc ? wrap(tail_q) : tail_q;
        cnt_d   = flush ? '0 : cnt_q + (IW+1)'(alloc) - (IW+1)'(commit);
        pend_d  = !flush && (alloc || (pend_q && !resolve));
        pidx_d  = alloc ? tail_q : pidx_q;
        {rs_qs1_d, rs_vs1_d} = res(rs1_q[pidx_q], iRF_Qs1, iRF_Vs1);
        {rs_qs2_d, rs_vs2_d} = res(rs2_q[pidx_q], iRF_Qs2, iRF_Vs2);
    end

    assign oIS_Full = full;
    assign oRF_Qn   = AW'(tail_q) + AW'(1);
    assign oRF_En   = rst && commit && enrd_q[head_q] && (rd_q[head_q] != '0);
    assign oRF_Rd   = (rst && commit) ? rd_q[head_q] : '0;
    assign oRF_Vd   = (rst && commit) ? val_q[head_q] : '0;
    assign oRS_En   = rs_en_q;
    assign oRS_Tag  = rs_tag_q;
    assign oRS_Qs1  = rs_qs1_q;
    assign oRS_Qs2  = rs_qs2_q;
    assign oRS_Vs1  = rs_vs1_q;
    assign oRS_Vs2  = rs_vs2_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            pidx_q   <= '0;
            rs_en_q  <= 1'b0;
            rs_tag_q <= '0;
            rs_qs1_q <= '0;
            rs_qs2_q <= '0;
            rs_vs1_q <= '0;
            rs_vs2_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            rs_en_q <= resolve;
            if (resolve) begin
                rs_tag_q <= AW'(pidx_q) + AW'(1);
                rs_qs1_q <= rs_qs1_d;
                rs_qs2_q <= rs_qs2_d;
                rs_vs1_q <= rs_vs1_d;
                rs_vs2_q <= rs_vs2_d;
            end
            if (flush)
                for (int i = 0; i < ROB_SIZE; i++) busy_q[i] <= 1'b0;
            if (cdb_ok) begin
                ready_q[cdb_idx] <= 1'b1;
                val_q[cdb_idx]   <= iCDB_Val;
            end
            if (commit) busy_q[head_q] <= 1'b0;
            // Allocation last: when full, a same-cycle commit frees exactly the slot being reused.
            if (alloc) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                enrd_q[tail_q]  <= iIS_EnRd;
                rd_q[tail_q]    <= iIS_Rd;
                rs1_q[tail_q]   <= iIS_Rs1;
                rs2_q[tail_q]   <= iIS_Rs2;
            end
        end
    end
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: scoreboard bench for rob_core; operand packets and commits are queued
// as expectations when stimulus is driven and popped when the DUT emits them.
module tb_rob_core;
    typedef struct packed {
        logic [4:0]  tag;
        logic [4:0]  q1;
        logic [31:0] v1;
        logic [4:0]  q2;
        logic [31:0] v2;
    } pkt_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] vd;
    } cm_t;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b1;
    logic        iIS_En, iIS_EnRd, iRF_En, iCDB_En;
    logic [4:0]  iIS_Rd, iIS_Rs1, iIS_Rs2, iRF_Qs1, iRF_Qs2, iCDB_Tag;
    logic [31:0] iRF_Vs1, iRF_Vs2, iCDB_Val;
    logic        oIS_Full, oRS_En, oRF_En;
    logic [4:0]  oRF_Qn, oRS_Tag, oRS_Qs1, oRS_Qs2, oRF_Rd;
    logic [31:0] oRS_Vs1, oRS_Vs2, oRF_Vd;
`ifdef ROB_FLUSH_EN
    logic        iFlush = 1'b0;
`endif
    pkt_t rs_q[$];
    cm_t  cm_q[$];
    pkt_t p;
    cm_t  c;
    int   n_chk = 0, n_fail = 0;

    rob_core dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef ROB_FLUSH_EN
        .iFlush(iFlush),
`endif
        .iIS_En(iIS_En), .iIS_EnRd(iIS_EnRd), .iIS_Rd(iIS_Rd), .iIS_Rs1(iIS_Rs1), .iIS_Rs2(iIS_Rs2),
        .oIS_Full(oIS_Full), .oRF_Qn(oRF_Qn),
        .iRF_En(iRF_En), .iRF_Qs1(iRF_Qs1), .iRF_Qs2(iRF_Qs2), .iRF_Vs1(iRF_Vs1), .iRF_Vs2(iRF_Vs2),
        .iCDB_En(iCDB_En), .iCDB_Tag(iCDB_Tag), .iCDB_Val(iCDB_Val),
        .oRS_En(oRS_En), .oRS_Tag(oRS_Tag), .oRS_Qs1(oRS_Qs1), .oRS_Qs2(oRS_Qs2),
        .oRS_Vs1(oRS_Vs1), .oRS_Vs2(oRS_Vs2),
        .oRF_En(oRF_En), .oRF_Rd(oRF_Rd), .oRF_Vd(oRF_Vd)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        iIS_En = 0; iIS_EnRd = 0; iIS_Rd = 0; iIS_Rs1 = 0; iIS_Rs2 = 0;
        iRF_En = 0; iRF_Qs1 = 0; iRF_Qs2 = 0; iRF_Vs1 = 0; iRF_Vs2 = 0;
        iCDB_En = 0; iCDB_Tag = 0; iCDB_Val = 0;
    endtask

    task automatic issue_in(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic enrd);
        iIS_En = 1; iIS_EnRd = enrd; iIS_Rd = rd; iIS_Rs1 = rs1; iIS_Rs2 = rs2;
    endtask

    task automatic push_rs(input logic [4:0] tag, input logic [4:0] q1, input logic [31:0] v1,
                           input logic [4:0] q2, input logic [31:0] v2);
        rs_q.push_back('{tag, q1, v1, q2, v2});
    endtask

    task automatic push_cm(input logic [4:0] rd, input logic [31:0] vd);
        cm_q.push_back('{rd, vd});
    endtask

    // Advance one cycle; at the falling edge drain whatever the DUT emits against the scoreboard.
    task automatic step();
        @(negedge clk);
        if (oRS_En === 1'b1) begin
            n_chk++;
            if (rs_q.size() == 0) begin
                n_fail++;
                $display("FAIL rs_pkt unexpected tag=%0d", oRS_Tag);
            end else begin
                p = rs_q.pop_front();
                if (oRS_Tag !== p.tag || oRS_Qs1 !== p.q1 || oRS_Qs2 !== p.q2 ||
                    (p.q1 == 0 && oRS_Vs1 !== p.v1) || (p.q2 == 0 && oRS_Vs2 !== p.v2)) begin
                    n_fail++;
                    $display("FAIL rs_pkt got tag=%0d q1=%0d v1=%h q2=%0d v2=%h exp tag=%0d q1=%0d v1=%h q2=%0d v2=%h",
                             oRS_Tag, oRS_Qs1, oRS_Vs1, oRS_Qs2, oRS_Vs2, p.tag, p.q1, p.v1, p.q2, p.v2);
                end
            end
        end
        if (oRF_En === 1'b1) begin
            n_chk++;
            if (cm_q.size() == 0) begin
                n_fail++;
                $display("FAIL commit unexpected rd=%0d vd=%h", oRF_Rd, oRF_Vd);
            end else begin
                c = cm_q.pop_front();
                if (oRF_Rd !== c.rd || oRF_Vd !== c.vd) begin
                    n_fail++;
                    $display("FAIL commit got rd=%0d vd=%h exp rd=%0d vd=%h", oRF_Rd, oRF_Vd, c.rd, c.vd);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic queues_empty(input string name);
        n_chk++;
        if (rs_q.size() != 0 || cm_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s outstanding rs=%0d commits=%0d exp 0 0", name, rs_q.size(), cm_q.size());
        end
        rs_q.delete();
        cm_q.delete();
    endtask

    task automatic test_reset();
        clr(); rst = 0;
        step(); step();
        #1;
        n_chk++; if (oRS_En !== 1'b0 || oRS_Tag !== 5'd0 || oRS_Qs1 !== 5'd0 || oRS_Vs1 !== 32'd0) begin n_fail++; $display("FAIL reset_rs got en=%b tag=%0d q1=%0d v1=%h exp 0", oRS_En, oRS_Tag, oRS_Qs1, oRS_Vs1); end
        n_chk++; if (oRF_En !== 1'b0 || oRF_Rd !== 5'd0 || oRF_Vd !== 32'd0) begin n_fail++; $display("FAIL reset_rf got en=%b rd=%0d vd=%h exp 0", oRF_En, oRF_Rd, oRF_Vd); end
        n_chk++; if (oIS_Full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", oIS_Full); end
        n_chk++; if (oRF_Qn !== 5'd1) begin n_fail++; $display("FAIL reset_qn got=%0d exp=1", oRF_Qn); end
        rst = 1;
        step();
    endtask

    task automatic test_basic();
        clr(); issue_in(5, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd1) begin n_fail++; $display("FAIL basic_qn got=%0d exp=1", oRF_Qn); end
        push_rs(1, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; iRF_Vs1 = 32'h1234; iRF_Vs2 = 32'h5678;
        step();
        clr(); #1;
        n_chk++; if (oRF_Qn !== 5'd2 || oIS_Full !== 1'b0) begin n_fail++; $display("FAIL basic_after got qn=%0d full=%b exp 2 0", oRF_Qn, oIS_Full); end
        step();
        iCDB_En = 1; iCDB_Tag = 1; iCDB_Val = 32'h11; push_cm(5, 32'h11);
        step();
        clr(); #1;
        n_chk++; if (oRF_En !== 1'b1) begin n_fail++; $display("FAIL basic_commit got=%b exp=1", oRF_En); end
        step();
        #1;
        n_chk++; if (oRF_En !== 1'b0) begin n_fail++; $display("FAIL basic_single_commit got=%b exp=0", oRF_En); end
        queues_empty("basic");
    endtask

    task automatic test_dependency();
        clr(); issue_in(3, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd2) begin n_fail++; $display("FAIL dep_qn_a got=%0d exp=2", oRF_Qn); end
        push_rs(2, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; step();
        clr(); issue_in(6, 3, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd3) begin n_fail++; $display("FAIL dep_qn_b got=%0d exp=3", oRF_Qn); end
        push_rs(3, 2, 0, 0, 0);
        step();
        clr(); iRF_En = 1; iRF_Qs1 = 2; iRF_Vs1 = 32'h999; step();
        clr(); step();
        iCDB_En = 1; iCDB_Tag = 2; iCDB_Val = 32'h55; push_cm(3, 32'h55);
        step();
        clr(); #1;
        n_chk++; if (oRF_En !== 1'b1 || oRF_Rd !== 5'd3 || oRF_Vd !== 32'h55) begin n_fail++; $display("FAIL dep_commit got en=%b rd=%0d vd=%h exp 1 3 55", oRF_En, oRF_Rd, oRF_Vd); end
        step();
        iCDB_En = 1; iCDB_Tag = 3; iCDB_Val = 32'h66; push_cm(6, 32'h66);
        step();
        clr(); step(); step();
        queues_empty("dependency");
    endtask

    task automatic test_forward();
        clr(); issue_in(3, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd4) begin n_fail++; $display("FAIL fwd_qn_a got=%0d exp=4", oRF_Qn); end
        push_rs(4, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; step();
        clr(); issue_in(8, 3, 0, 1); push_rs(5, 0, 32'hAB, 0, 0);
        step();
        clr(); iRF_En = 1; iRF_Qs1 = 4; iRF_Vs1 = 32'h77;
        iCDB_En = 1; iCDB_Tag = 4; iCDB_Val = 32'hAB; push_cm(3, 32'hAB);
        step();
        clr(); issue_in(10, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd6 || oRF_En !== 1'b1) begin n_fail++; $display("FAIL fwd_c_issue got qn=%0d commit=%b exp 6 1", oRF_Qn, oRF_En); end
        push_rs(6, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; step();
        clr(); iCDB_En = 1; iCDB_Tag = 6; iCDB_Val = 32'hC6; step();
        clr(); issue_in(11, 10, 3, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd7 || oRF_En !== 1'b0) begin n_fail++; $display("FAIL fwd_in_order got qn=%0d commit=%b exp 7 0", oRF_Qn, oRF_En); end
        push_rs(7, 0, 32'hC6, 0, 32'h33);
        step();
        clr(); iRF_En = 1; iRF_Qs1 = 6; iRF_Vs1 = 32'h1; iRF_Qs2 = 4; iRF_Vs2 = 32'h33; step();
        clr(); step();
        iCDB_En = 1; iCDB_Tag = 5; iCDB_Val = 32'h5; push_cm(8, 32'h5); push_cm(10, 32'hC6);
        step();
        clr(); iCDB_En = 1; iCDB_Tag = 7; iCDB_Val = 32'h7; push_cm(11, 32'h7);
        step();
        clr(); step(); step();
        queues_empty("forward");
    endtask

    task automatic test_reset_mid();
        clr(); issue_in(12, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd8) begin n_fail++; $display("FAIL rstmid_qn got=%0d exp=8", oRF_Qn); end
        push_rs(8, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; step();
        clr(); step();
        iCDB_En = 1; iCDB_Tag = 8; iCDB_Val = 32'h88; step();
        clr(); rst = 0; #1;
        n_chk++; if (oRF_En !== 1'b0 || oRF_Rd !== 5'd0 || oRF_Vd !== 32'd0) begin n_fail++; $display("FAIL rstmid_rf_forced got en=%b rd=%0d vd=%h exp 0", oRF_En, oRF_Rd, oRF_Vd); end
        step();
        rst = 1; #1;
        n_chk++; if (oRF_Qn !== 5'd1 || oIS_Full !== 1'b0 || oRF_En !== 1'b0 || oRS_En !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear got qn=%0d full=%b rf=%b rs=%b exp 1 0 0 0", oRF_Qn, oIS_Full, oRF_En, oRS_En); end
        step(); step();
        queues_empty("reset_mid");
    endtask

    task automatic test_enable();
        clr(); en = 0; issue_in(1, 0, 0, 1);
        step();
        clr(); en = 1; iRF_En = 1; #1;
        n_chk++; if (oRF_Qn !== 5'd1) begin n_fail++; $display("FAIL enable_hold got qn=%0d exp=1", oRF_Qn); end
        step();
        clr(); step();
        queues_empty("enable");
    endtask

    task automatic test_back_to_back_fill();
        for (int k = 1; k <= 16; k++) begin
            clr(); issue_in(5'(k), 0, 0, 1); iRF_En = (k > 1); #1;
            n_chk++; if (oRF_Qn !== 5'(k) || oIS_Full !== 1'b0) begin n_fail++; $display("FAIL fill_qn k=%0d got qn=%0d full=%b exp %0d 0", k, oRF_Qn, oIS_Full, k); end
            push_rs(5'(k), 0, 0, 0, 0);
            step();
        end
        clr(); issue_in(20, 0, 0, 1); iRF_En = 1; #1;
        n_chk++; if (oIS_Full !== 1'b1 || oRF_Qn !== 5'd1) begin n_fail++; $display("FAIL fill_full got full=%b qn=%0d exp 1 1", oIS_Full, oRF_Qn); end
        step();
        clr(); #1;
        n_chk++; if (oIS_Full !== 1'b1 || oRF_Qn !== 5'd1) begin n_fail++; $display("FAIL fill_17th_ignored got full=%b qn=%0d exp 1 1", oIS_Full, oRF_Qn); end
        step();
        iCDB_En = 1; iCDB_Tag = 1; iCDB_Val = 32'h101; push_cm(1, 32'h101);
        step();
        clr(); issue_in(21, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd1 || oIS_Full !== 1'b1 || oRF_En !== 1'b1) begin n_fail++; $display("FAIL fill_commit_alloc got qn=%0d full=%b commit=%b exp 1 1 1", oRF_Qn, oIS_Full, oRF_En); end
        push_rs(1, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; #1;
        n_chk++; if (oIS_Full !== 1'b1 || oRF_Qn !== 5'd2) begin n_fail++; $display("FAIL fill_count_kept got full=%b qn=%0d exp 1 2", oIS_Full, oRF_Qn); end
        step();
        clr(); step();
        queues_empty("fill");
    endtask

    task automatic test_stale();
        int t;
        clr(); iCDB_En = 1; iCDB_Tag = 2; iCDB_Val = 32'h202; push_cm(2, 32'h202); step();
        clr(); step();
        issue_in(7, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd2 || oIS_Full !== 1'b0) begin n_fail++; $display("FAIL stale_realloc got qn=%0d full=%b exp 2 0", oRF_Qn, oIS_Full); end
        push_rs(2, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; step();
        clr(); step();
        iCDB_En = 1; iCDB_Tag = 3; iCDB_Val = 32'h303; push_cm(3, 32'h303); step();
        clr(); step();
        issue_in(13, 4, 21, 0); #1;
        n_chk++; if (oRF_Qn !== 5'd3) begin n_fail++; $display("FAIL stale_qn got=%0d exp=3", oRF_Qn); end
        push_rs(3, 0, 32'h444, 1, 0);
        step();
        clr(); iRF_En = 1; iRF_Qs1 = 2; iRF_Vs1 = 32'h444; iRF_Qs2 = 1; iRF_Vs2 = 32'h5A5; step();
        clr(); step();
        for (int i = 0; i < 16; i++) begin
            t = (i < 13) ? i + 4 : i - 12;
            clr(); iCDB_En = 1; iCDB_Tag = 5'(t); iCDB_Val = 32'h1000 + 32'(t);
            if (t != 3) push_cm((t == 1) ? 5'd21 : (t == 2) ? 5'd7 : 5'(t), 32'h1000 + 32'(t));
            step();
        end
        clr(); step(); step();
        #1;
        n_chk++; if (oIS_Full !== 1'b0 || oRF_Qn !== 5'd4) begin n_fail++; $display("FAIL drain_state got full=%b qn=%0d exp 0 4", oIS_Full, oRF_Qn); end
        queues_empty("stale_drain");
    endtask

`ifdef ROB_FLUSH_EN
    task automatic test_flush();
        for (int k = 0; k < 4; k++) begin
            clr(); issue_in(5'(20 + k), 0, 0, 1); iRF_En = (k > 0); #1;
            n_chk++; if (oRF_Qn !== 5'(4 + k)) begin n_fail++; $display("FAIL flush_fill_qn got=%0d exp=%0d", oRF_Qn, 4 + k); end
            if (k < 3) push_rs(5'(4 + k), 0, 0, 0, 0);
            step();
        end
        clr(); iFlush = 1; iRF_En = 1; iIS_En = 1; iIS_Rd = 30; step();
        iFlush = 0; clr(); #1;
        n_chk++; if (oRF_Qn !== 5'd1 || oIS_Full !== 1'b0 || oRS_En !== 1'b0) begin n_fail++; $display("FAIL flush_state got qn=%0d full=%b rs=%b exp 1 0 0", oRF_Qn, oIS_Full, oRS_En); end
        iCDB_En = 1; iCDB_Tag = 4; iCDB_Val = 32'hDEAD; step();
        clr(); step(); step();
        issue_in(9, 0, 0, 1); #1;
        n_chk++; if (oRF_Qn !== 5'd1) begin n_fail++; $display("FAIL flush_next_tag got=%0d exp=1", oRF_Qn); end
        push_rs(1, 0, 0, 0, 0);
        step();
        clr(); iRF_En = 1; step();
        clr(); iCDB_En = 1; iCDB_Tag = 1; iCDB_Val = 32'h99; push_cm(9, 32'h99); step();
        clr(); step(); step();
        queues_empty("flush");
    endtask
`endif

    initial begin
        clr();
        test_reset();
        test_basic();
        test_dependency();
        test_forward();
        test_reset_mid();
        test_enable();
        test_back_to_back_fill();
        test_stale();
`ifdef ROB_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_core.md
Name: rob_core

Overview:
- Reorder buffer sitting between issue and the register file / reservation stations.
- Allocates in-order tags to issued instructions and supplies the tag to the register file for rename (q[rd]).
- Resolves source operands from the register file's returned Q/V against in-flight entries and the CDB.
- Sends resolved operands to the reservation stations; commits completed results in order back to the register file.

Parameters:
- ROB_SIZE, 16, entry count; entry i carries tag i+1; tag 0 = "no dependency"; must be <= 2^REG_ADD_W - 1.
- REG_ADD_W, 5, register index / tag width.
- REG_DAT_W, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- en  in  1  global enable; when 0, all state holds and no handshake is accepted
- iIS_En  in  1  issue request
- iIS_EnRd  in  1  instruction writes rd
- iIS_Rd  in  REG_ADD_W  destination register
- iIS_Rs1 / iIS_Rs2  in  REG_ADD_W  source register indices
- oIS_Full  out  1  ROB full; issue must not assert iIS_En
- oRF_Qn  out  REG_ADD_W  tag of the next free entry (tail), combinational
- iRF_En  in  1  register file Q/V response valid
- iRF_Qs1 / iRF_Qs2  in  REG_ADD_W  tags returned by the register file
- iRF_Vs1 / iRF_Vs2  in  REG_DAT_W  values returned by the register file
- iCDB_En  in  1  result broadcast valid
- iCDB_Tag  in  REG_ADD_W  tag of the completing entry
- iCDB_Val  in  REG_DAT_W  result value
- oRS_En  out  1  resolved operand packet valid
- oRS_Tag  out  REG_ADD_W  tag of the issued instruction
- oRS_Qs1 / oRS_Qs2  out  REG_ADD_W  0 if the operand is ready, else the producer tag
- oRS_Vs1 / oRS_Vs2  out  REG_DAT_W  operand value, valid when the matching Q = 0
- oRF_En  out  1  commit write enable, combinational
- oRF_Rd  out  REG_ADD_W  commit destination
- oRF_Vd  out  REG_DAT_W  commit value

Behaviour:
- Reset (rst=0 at posedge):
  - head = tail = count = 0; all busy/ready bits cleared.
  - oRS_En = 0; oRS_* = 0; pending-issue latch cleared.
  - oRF_En / oRF_Rd / oRF_Vd forced to 0 while rst = 0.
  - Reset mid-operation discards every in-flight entry.
- Entry fields: busy, ready, enrd, rd, value, rs1, rs2.
- oIS_Full = (count == ROB_SIZE). iIS_En while full is ignored.
- Allocation, cycle t (iIS_En & !full):
  - Entry[tail] gets busy=1, ready=0, enrd, rd, rs1, rs2.
  - oRF_Qn = tail+1 during cycle t; the register file captures it the same edge.
  - tail wraps ROB_SIZE-1 -> 0.
  - Tag of this instruction is latched for the resolve stage.
- Resolve, cycle t+1 (iRF_En = 1): issue holds iIS_Rs1/iIS_Rs2 stable through t+1 so that iRF_Vs* is valid. Per source s:
  - rs == 0 -> Q = 0, V = 0.
  - Qs == 0 -> Q = 0, V = iRF_Vs.
  - Qs != 0 and entry[Qs-1] is not busy, or entry.rd != rs -> stale tag; Q = 0, V = iRF_Vs.
  - Entry busy, rd matches, ready -> Q = 0, V = entry.value.
  - Entry busy, rd matches, not ready, and iCDB_En & iCDB_Tag == Qs -> Q = 0, V = iCDB_Val.
  - Otherwise Q = Qs.
  - The packet is registered: oRS_En = 1 for exactly one cycle at t+2.
- CDB: iCDB_En marks entry[iCDB_Tag-1] ready and stores the value. A tag naming a non-busy entry is ignored.
- Commit:
  - When entry[head] is busy & ready: oRF_En = enrd & (rd != 0), oRF_Rd = rd, oRF_Vd = value, all combinational.
  - At that edge: busy cleared, head advances (wraps), count decrements. Maximum 1 commit per cycle.
  - An entry with enrd = 0 retires silently.
- Same-cycle allocate + commit: count unchanged; full is allowed to allocate only if a commit frees an entry that same cycle.
- A CDB write to the head entry makes it committable in the following cycle (no same-cycle bypass).
- en = 0: no allocation, commit, CDB capture, or oRS_En.

Optional Feature:
- ROB_FLUSH_EN: adds input iFlush.
- With the macro: iFlush = 1 at a posedge clears all busy bits, sets head = tail = count = 0, and forces oRS_En = 0 the next cycle. The flush has priority over allocate, CDB and commit that cycle.
- Without the macro: the port is absent; entries drain only via commit.

Test Plan:
- Reset with rst=0, then issue rd=5, rs1=rs2=0 -> oRF_Qn=1 at t; oRS_En=1 at t+2 with Tag=1, Qs1=Qs2=0, Vs=0; count=1.
- Issue A (rd=3, tag 1), then B (rs1=3) with iRF_Qs1=1 -> oRS_Qs1=1. Then CDB tag 1, value 0x55 -> oRF_En=1, Rd=3, Vd=0x55 next cycle; head=1.
- Same-cycle forward: B's resolve cycle coincides with CDB tag 1, value 0xAB -> oRS_Qs1=0, oRS_Vs1=0xAB.
- Stale tag: tag 2 committed and reallocated to rd=7, source rs1=4 with iRF_Qs1=2 -> Q=0, V=iRF_Vs1.
- Fill 16 entries -> oIS_Full=1, the 17th iIS_En is ignored. Commit head while issuing -> allocation at tag 1 after wrap, count stays 16.
- ROB_FLUSH_EN: 4 entries in flight, iFlush=1 -> count=0, oIS_Full=0, no oRF_En afterwards; the next issue gets tag 1.
